// File: rtl/uart_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_frame_rx : host frame decoder (AA 55 LEN payload [CK]) into a word FIFO |
// | Optional checksum byte enabled by macro UART_FRAME_CKSUM_EN.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module uart_frame_rx #(
    parameter logic [7:0]  HDR0    = 8'hAA,
    parameter logic [7:0]  HDR1    = 8'h55,
    parameter logic [15:0] TIMEOUT = 16'd2000,
    parameter int          FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdsig,
    input  logic [7:0]  rxdata,
    input  logic        dataerror,
    input  logic        frameerror,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] word_cnt,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int c_DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_LEN  = 3'd2,
`ifdef UART_FRAME_CKSUM_EN
        S_CK   = 3'd4,
`endif
        S_PAY  = 3'd3
    } state_t;

    state_t      r_state;
    logic        r_rdsig_d;
    logic        r_byte_vld;
    logic [7:0]  r_byte;
    logic        r_byte_err;
    logic [15:0] r_tmo;
    logic [9:0]  r_rem;
    logic [1:0]  r_pos;
    logic [23:0] r_word;
    logic [15:0] r_word_cnt;
    logic        r_done;
    logic        r_err;
`ifdef UART_FRAME_CKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic [31:0]      r_mem [c_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;

    logic w_empty, w_full, w_pop, w_word_byte, w_push, w_ovf;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]) &&
                         (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);
    assign w_pop       = !w_empty && word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
    assign w_word_byte = r_byte_vld && !r_byte_err && (r_state == S_PAY) && (r_pos == 2'd3);
    assign w_push      = w_word_byte && (!w_full || w_pop);
    assign w_ovf       = w_word_byte && w_full && !w_pop;

    assign word_valid = !w_empty;
    assign word_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign word_cnt   = r_word_cnt;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdsig_d  <= 1'b0;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'd0;
            r_byte_err <= 1'b0;
        end else begin
            r_rdsig_d  <= rdsig;
            r_byte_vld <= rdsig && !r_rdsig_d;
            r_byte     <= rxdata;
            r_byte_err <= dataerror || frameerror;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tmo      <= 16'd0;
            r_rem      <= 10'd0;
            r_pos      <= 2'd0;
            r_word     <= 24'd0;
            r_word_cnt <= 16'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (!r_byte_vld) begin
                if (r_state != S_IDLE) begin
                    if (r_tmo == TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            end else begin
                r_tmo <= 16'd0;
                if (r_state != S_IDLE && r_byte_err) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (r_byte == HDR0 && !r_byte_err) begin
                                r_state    <= S_H1;
                                r_word_cnt <= 16'd0;
`ifdef UART_FRAME_CKSUM_EN
                                r_sum      <= 8'd0;
`endif
                            end
                        end
                        S_H1: begin
                            if (r_byte == HDR1)      r_state <= S_LEN;
                            else if (r_byte != HDR0) r_state <= S_IDLE;
                        end
                        S_LEN: begin
                            if (r_byte == 8'd0) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_rem   <= {r_byte, 2'b00};
                                r_pos   <= 2'd0;
                                r_state <= S_PAY;
`ifdef UART_FRAME_CKSUM_EN
                                r_sum   <= r_sum + r_byte;
`endif
                            end
                        end
                        S_PAY: begin
                            r_word <= {r_word[15:0], r_byte};
                            r_pos  <= r_pos + 2'd1;
                            r_rem  <= r_rem - 10'd1;
`ifdef UART_FRAME_CKSUM_EN
                            r_sum  <= r_sum + r_byte;
`endif
                            if (w_ovf) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                if (w_push) r_word_cnt <= r_word_cnt + 16'd1;
                                if (r_rem == 10'd1) begin
`ifdef UART_FRAME_CKSUM_EN
                                    r_state <= S_CK;
`else
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
`endif
                                end
                            end
                        end
`ifdef UART_FRAME_CKSUM_EN
                        S_CK: begin
                            if (r_byte == r_sum) r_done <= 1'b1;
                            else                 r_err  <= 1'b1;
                            r_state <= S_IDLE;
                        end
`endif
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {r_word, r_byte};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_frame_rx : randomized frame stimulus against a frame-level model     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_uart_frame_rx;

    localparam logic [7:0] c_HDR0  = 8'hAA;
    localparam logic [7:0] c_HDR1  = 8'h55;
    localparam int         c_TMO   = 2000;
    localparam int         c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdsig = 1'b0;
    logic [7:0]  rxdata = 8'd0;
    logic        dataerror = 1'b0;
    logic        frameerror = 1'b0;
    logic        word_ready = 1'b1;
    logic [31:0] word_data;
    logic        word_valid;
    logic [15:0] word_cnt;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    uart_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .rdsig(rdsig), .rxdata(rxdata),
        .dataerror(dataerror), .frameerror(frameerror),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .word_cnt(word_cnt), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: bytes of the frame in progress are kept in fb,
    // and all decisions are made from the frame's byte index.
    logic [7:0]  fb[$];
    logic [31:0] m_q[$];
    logic [31:0] m_log[$];
    int          m_idle = 0;
    int          m_done_cnt = 0;
    int          m_err_cnt = 0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_rd_d = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_pend_err = 1'b0;
    logic [7:0]  m_pend_b = 8'd0;

    task automatic m_abort();
        m_err = 1'b1;
        m_err_cnt++;
        fb.delete();
    endtask

    always @(posedge clk) begin
        logic        acc, acc_err;
        logic [7:0]  b, s;
        logic [31:0] w;
        int          pos, n, i;
        acc        = m_pend;
        b          = m_pend_b;
        acc_err    = m_pend_err;
        m_pend     = rdsig && !m_rd_d;
        m_pend_b   = rxdata;
        m_pend_err = dataerror || frameerror;
        m_rd_d     = rdsig;
        m_done     = 1'b0;
        m_err      = 1'b0;
        if (!rst_n) begin
            fb.delete();
            m_q.delete();
            m_cnt  = 16'd0;
            m_idle = 0;
            m_pend = 1'b0;
            m_rd_d = 1'b0;
        end else begin
            if (m_q.size() != 0 && word_ready) void'(m_q.pop_front());
            if (fb.size() == 0) begin
                if (acc && !acc_err && b == c_HDR0) begin
                    fb.push_back(b);
                    m_cnt  = 16'd0;
                    m_idle = 0;
                end
            end else if (acc) begin
                m_idle = 0;
                pos = fb.size();
                if (acc_err) m_abort();
                else if (pos == 1) begin
                    if (b == c_HDR1) fb.push_back(b);
                    else if (b != c_HDR0) fb.delete();
                end else if (pos == 2) begin
                    if (b == 8'd0) m_abort();
                    else fb.push_back(b);
                end else begin
                    n = int'(fb[2]);
                    i = pos - 3;
                    if (i < 4 * n) begin
                        if (i % 4 == 3) begin
                            w = {fb[pos-3], fb[pos-2], fb[pos-1], b};
                            if (m_q.size() >= c_DEPTH) m_abort();
                            else begin
                                fb.push_back(b);
                                m_q.push_back(w);
                                m_log.push_back(w);
                                m_cnt++;
`ifndef UART_FRAME_CKSUM_EN
                                if (i == 4 * n - 1) begin
                                    m_done = 1'b1;
                                    m_done_cnt++;
                                    fb.delete();
                                end
`endif
                            end
                        end else begin
                            fb.push_back(b);
                        end
                    end else begin
                        s = 8'd0;
                        for (int k = 2; k < fb.size(); k++) s = s + fb[k];
                        if (s == b) begin
                            m_done = 1'b1;
                            m_done_cnt++;
                        end else begin
                            m_err = 1'b1;
                            m_err_cnt++;
                        end
                        fb.delete();
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == c_TMO + 1) m_abort();
            end
        end
    end

    int d_done = 0;
    int d_err  = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("word_valid", word_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("word_data", word_data, m_q[0]);
            check("word_cnt", word_cnt, m_cnt);
            check("frame_done", frame_done, m_done);
            check("frame_err", frame_err, m_err);
            check("busy", busy, fb.size() != 0);
            if (frame_done) d_done++;
            if (frame_err)  d_err++;
        end
    end

    int ready_mode = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (ready_mode == 0)      word_ready = 1'b1;
            else if (ready_mode == 1) word_ready = 1'b0;
            else                      word_ready = ($urandom_range(0, 1) == 1);
        end
    end

    logic [7:0] tx[$];

    function automatic logic [7:0] tx_sum(input int from);
        logic [7:0] s;
        s = 8'd0;
        for (int i = from; i < tx.size(); i++) s = s + tx[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit e);
        @(negedge clk);
        rxdata = b;
        dataerror = 1'b0;
        frameerror = 1'b0;
        if (e) begin
            if ($urandom_range(0, 1) == 1) dataerror = 1'b1;
            else frameerror = 1'b1;
        end
        rdsig = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rdsig = 1'b0;
        dataerror = 1'b0;
        frameerror = 1'b0;
        rxdata = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_tx(input int err_idx);
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], i == err_idx);
        repeat (6) @(negedge clk);
    endtask

    task automatic build_frame(input int n, input bit bad_ck);
        tx = '{c_HDR0, c_HDR1};
        tx.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom));
`ifdef UART_FRAME_CKSUM_EN
        tx.push_back(tx_sum(2) + (bad_ck ? 8'd1 : 8'd0));
`else
        if (bad_ck) tx.push_back(8'h00);
`endif
    endtask

    task automatic drain();
        int t;
        ready_mode = 0;
        t = 0;
        while (m_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", word_valid, 1'b0);
    endtask

    int b_log, b_done, b_err, b_ddone, b_derr;

    task automatic mark();
        b_log = m_log.size(); b_done = m_done_cnt; b_err = m_err_cnt;
        b_ddone = d_done; b_derr = d_err;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_word_data", word_data, 32'd0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_cnt", word_cnt, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {frame_done, frame_err}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good two-word frame
        mark();
        tx = '{8'hAA, 8'h55, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        check("cksum_calc", tx_sum(2), 8'h66);
`ifdef UART_FRAME_CKSUM_EN
        tx.push_back(tx_sum(2));
`endif
        send_tx(-1);
        check("t1_words", m_log.size() - b_log, 2);
        check("t1_word0", m_log[b_log], 32'h11223344);
        check("t1_word1", m_log[b_log+1], 32'h55667788);
        check("t1_model_done", m_done_cnt - b_done, 1);
        check("t1_dut_done", d_done - b_ddone, 1);
        check("t1_dut_err", d_err - b_derr, 0);
        check("t1_word_cnt", word_cnt, 16'd2);

`ifdef UART_FRAME_CKSUM_EN
        // Bad checksum: words still delivered, frame flagged
        mark();
        tx[tx.size()-1] = tx[tx.size()-1] + 8'd1;
        send_tx(-1);
        check("t2_words", m_log.size() - b_log, 2);
        check("t2_dut_err", d_err - b_derr, 1);
        check("t2_dut_done", d_done - b_ddone, 0);
`endif

        // Overflow with consumer stalled
        mark();
        ready_mode = 1;
        tx = '{8'hAA, 8'h55, 8'h05};
        for (int i = 1; i <= 20; i++) tx.push_back(8'(i));
`ifdef UART_FRAME_CKSUM_EN
        tx.push_back(tx_sum(2));
`endif
        send_tx(-1);
        check("t3_model_err", m_err_cnt - b_err, 1);
        check("t3_dut_err", d_err - b_derr, 1);
        check("t3_fifo_words", m_q.size(), 4);
        check("t3_word_cnt", word_cnt, 16'd4);
        drain();

        // Header resync with leading junk
        mark();
        tx = '{8'h00, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef UART_FRAME_CKSUM_EN
        tx.push_back(tx_sum(5));
`endif
        send_tx(-1);
        check("t4_word", m_log[m_log.size()-1], 32'hDEADBEEF);
        check("t4_dut_done", d_done - b_ddone, 1);

        // Inter-byte timeout
        mark();
        tx = '{8'hAA, 8'h55, 8'h01, 8'h12};
        send_tx(-1);
        check("t5_busy_before", busy, 1'b1);
        repeat (c_TMO + 5) @(negedge clk);
        check("t5_dut_err", d_err - b_derr, 1);
        check("t5_busy_after", busy, 1'b0);
        mark();
        build_frame(1, 1'b0);
        send_tx(-1);
        check("t5_next_done", d_done - b_ddone, 1);

        // Reset in the middle of the payload
        ready_mode = 1;
        tx = '{8'hAA, 8'h55, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_valid", word_valid, 1'b0);
        check("t6_word_cnt", word_cnt, 16'd0);
        check("t6_busy", busy, 1'b0);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        mark();
        tx = '{8'hAA, 8'h55, 8'h00};
        send_tx(-1);
        check("t6_len0_err", d_err - b_derr, 1);

        // Randomized traffic
        ready_mode = 2;
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5)      build_frame($urandom_range(1, 6), 1'b0);
            else if (kind == 6) build_frame($urandom_range(1, 3), 1'b1);
            else if (kind == 7) tx = '{c_HDR0, c_HDR1, 8'h00};
            else if (kind == 8) begin
                tx.delete();
                repeat ($urandom_range(1, 6)) tx.push_back(8'($urandom));
            end else build_frame($urandom_range(1, 3), 1'b0);
            send_tx(kind == 9 ? int'($urandom_range(1, 6)) : -1);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
